// File: rtl/std_fp_accum_pipe.sv
// Unsigned fixed-point streaming accumulator with guard bits and output saturation.
// Latency: 1 + (beats + bubbles) + 2 cycles from go to done; in_ready is registered and asserted only in ACCUM.
module std_fp_accum_pipe #(
    parameter int WIDTH       = 32,
    parameter int INT_WIDTH   = 16,
    parameter int FRAC_WIDTH  = 16,
    parameter int GUARD       = 8,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   go,
    input  logic [COUNT_WIDTH-1:0] len,
    input  logic                   in_valid,
    input  logic [WIDTH-1:0]       in_data,
    output logic                   in_ready,
    output logic [WIDTH-1:0]       out,
    output logic                   overflow,
    output logic                   done
);
    // Accumulator width is the full format plus guard bits (INT_WIDTH + FRAC_WIDTH == WIDTH).
    localparam int AW = INT_WIDTH + FRAC_WIDTH + GUARD;
    localparam logic [COUNT_WIDTH-1:0] CNT_ONE = COUNT_WIDTH'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        FINAL = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [AW-1:0]          acc_q, acc_d;
    logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [COUNT_WIDTH-1:0] len_q, len_d;
    logic                   sticky_q, sticky_d;
    logic [WIDTH-1:0]       out_q, out_d;
    logic                   overflow_q, overflow_d;
    logic                   done_q, done_d;
    logic                   in_ready_q, in_ready_d;
    logic [AW:0]            sum;

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        len_d      = len_q;
        sticky_d   = sticky_q;
        out_d      = out_q;
        overflow_d = overflow_q;
        done_d     = 1'b0;
        in_ready_d = 1'b0;
        sum        = {1'b0, acc_q} + {{(AW - WIDTH + 1){1'b0}}, in_data};

        case (state_q)
            IDLE: begin
                if (go) begin
                    len_d      = len;
                    acc_d      = '0;
                    cnt_d      = '0;
                    sticky_d   = 1'b0;
                    out_d      = '0;
                    overflow_d = 1'b0;
                    if (len != '0) begin
                        state_d    = ACCUM;
                        in_ready_d = 1'b1;
                    end else begin
                        state_d = FINAL;
                    end
                end
            end
            ACCUM: begin
                in_ready_d = 1'b1;
                if (in_valid) begin
                    // A carry out of the guard bits pins the accumulator and remembers it.
                    if (sum[AW]) begin
                        acc_d    = '1;
                        sticky_d = 1'b1;
                    end else begin
                        acc_d = sum[AW-1:0];
                    end
                    cnt_d = cnt_q + CNT_ONE;
                    if (cnt_q == len_q - CNT_ONE) begin
                        state_d    = FINAL;
                        in_ready_d = 1'b0;
                    end
                end
            end
            FINAL: begin
                if (sticky_q || (acc_q[AW-1:WIDTH] != '0)) begin
                    out_d      = '1;
                    overflow_d = 1'b1;
                end else begin
                    out_d      = acc_q[WIDTH-1:0];
                    overflow_d = 1'b0;
                end
                done_d  = 1'b1;
                state_d = DONE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            acc_q      <= '0;
            cnt_q      <= '0;
            len_q      <= '0;
            sticky_q   <= 1'b0;
            out_q      <= '0;
            overflow_q <= 1'b0;
            done_q     <= 1'b0;
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            len_q      <= len_d;
            sticky_q   <= sticky_d;
            out_q      <= out_d;
            overflow_q <= overflow_d;
            done_q     <= done_d;
            in_ready_q <= in_ready_d;
        end
    end

    assign in_ready = in_ready_q;
    assign out      = out_q;
    assign overflow = overflow_q;
    assign done     = done_q;

endmodule

// File: tb/tb_std_fp_accum_pipe.sv
// Randomized bench for std_fp_accum_pipe in an 8-bit Q4.4 format with 2 guard bits.
module tb_std_fp_accum_pipe;

    logic        clk;
    logic        reset;
    logic        go;
    logic [15:0] len;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic [7:0]  out;
    logic        overflow;
    logic        done;

    int          n_checks;
    int          n_errors;
    logic [7:0]  terms[$];

    std_fp_accum_pipe #(
        .WIDTH      (8),
        .INT_WIDTH  (4),
        .FRAC_WIDTH (4),
        .GUARD      (2),
        .COUNT_WIDTH(16)
    ) u_dut (
        .clk     (clk),
        .reset   (reset),
        .go      (go),
        .len     (len),
        .in_valid(in_valid),
        .in_data (in_data),
        .in_ready(in_ready),
        .out     (out),
        .overflow(overflow),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Runs one operation over the queued terms. Called at a negedge in IDLE; returns at a negedge in IDLE.
    // Expected result: exact integer sum, clamped to 0xFF whenever it does not fit the 8-bit format.
    task automatic do_op(input int gaps, input int bubble_pct, input bit busy_go);
        int         n;
        int         true_sum;
        int         beats;
        int         cycles;
        int         gaps_left;
        logic [7:0] exp_out;
        logic       exp_ovf;
        n = terms.size();
        true_sum = 0;
        foreach (terms[i]) true_sum += int'(terms[i]);
        exp_ovf = (true_sum > 255);
        exp_out = exp_ovf ? 8'hFF : true_sum[7:0];
        gaps_left = gaps;

        go  = 1'b1;
        len = n[15:0];
        @(negedge clk);
        go  = 1'b0;
        len = 16'($urandom);
        chk("start_clr_out", {24'd0, out}, 32'd0);
        chk("start_clr_ovf", {31'd0, overflow}, 32'd0);

        beats  = 0;
        cycles = 0;
        while (beats < n && cycles < 200) begin
            chk("ready_accum", {31'd0, in_ready}, 32'd1);
            chk("no_done_accum", {31'd0, done}, 32'd0);
            if (beats == 1 && gaps_left > 0) begin
                in_valid = 1'b0;
                in_data  = 8'($urandom);
                gaps_left--;
            end else if (int'($urandom_range(0, 99)) < bubble_pct) begin
                in_valid = 1'b0;
                in_data  = 8'($urandom);
            end else begin
                in_valid = 1'b1;
                in_data  = terms[beats];
            end
            go = busy_go && ($urandom_range(0, 1) == 1);
            @(posedge clk);
            if (in_valid) beats++;
            @(negedge clk);
            cycles++;
        end
        if (cycles >= 200) chk("beat_budget", cycles, 0);

        in_valid = 1'b0;
        go       = 1'b0;
        chk("ready_final", {31'd0, in_ready}, 32'd0);
        chk("no_done_final", {31'd0, done}, 32'd0);
        @(negedge clk);
        chk("done_pulse", {31'd0, done}, 32'd1);
        chk("result_out", {24'd0, out}, {24'd0, exp_out});
        chk("result_ovf", {31'd0, overflow}, {31'd0, exp_ovf});
        chk("ready_done", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        chk("done_one_cycle", {31'd0, done}, 32'd0);
        chk("out_hold", {24'd0, out}, {24'd0, exp_out});
        chk("ovf_hold", {31'd0, overflow}, {31'd0, exp_ovf});
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset    = 1'b0;
        go       = 1'b0;
        len      = 16'd0;
        in_valid = 1'b0;
        in_data  = 8'd0;

        #3;
        chk("rst_out", {24'd0, out}, 32'd0);
        chk("rst_ovf", {31'd0, overflow}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_ready", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // 1.0 + 1.5 + 0.5 = 3.0
        terms = '{8'h10, 8'h18, 8'h08};
        do_op(0, 0, 1'b0);
        // Output saturation: 0xF0 + 0x20 = 0x110
        terms = '{8'hF0, 8'h20};
        do_op(0, 0, 1'b0);
        // Guard saturation: five 0xFF beats overflow the 10-bit accumulator
        terms = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        do_op(0, 0, 1'b0);
        // Bubbles between beats with go pulsed while busy
        terms = '{8'h04, 8'h06};
        do_op(2, 0, 1'b1);
        // Zero length
        terms = {};
        do_op(0, 0, 1'b0);

        // Reset after one of three beats
        go  = 1'b1;
        len = 16'd3;
        @(negedge clk);
        go       = 1'b0;
        in_valid = 1'b1;
        in_data  = 8'h05;
        @(negedge clk);
        in_valid = 1'b0;
        reset    = 1'b0;
        #1;
        chk("abort_out", {24'd0, out}, 32'd0);
        chk("abort_ovf", {31'd0, overflow}, 32'd0);
        chk("abort_ready", {31'd0, in_ready}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("abort_no_done", {31'd0, done}, 32'd0);
            chk("abort_idle_ready", {31'd0, in_ready}, 32'd0);
        end
        terms = '{8'h07};
        do_op(0, 0, 1'b0);

        for (int op = 0; op < 40; op++) begin
            int nt;
            nt = int'($urandom_range(0, 6));
            terms = {};
            for (int j = 0; j < nt; j++) begin
                if ($urandom_range(0, 3) == 0) terms.push_back(8'($urandom_range(128, 255)));
                else terms.push_back(8'($urandom_range(0, 60)));
            end
            do_op(0, 30, ($urandom_range(0, 1) == 1));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/std_fp_accum_pipe.md
# std_fp_accum_pipe

Unsigned fixed-point streaming accumulator that consumes the product stream of the pipelined fixed-point multiplier and sums a programmed number of terms into one `WIDTH`-bit result. Together with the multiplier it forms the accumulate half of a dot-product or MAC datapath. It uses the standard `go`/`done` start handshake and a `valid`/`ready` input beat. The datapath carries guard bits and saturates the final result to the `WIDTH`-bit format.

## Interface
- `WIDTH`, 32, total bits of the input and output fixed-point format.
- `INT_WIDTH`, 16, integer bits. Informational only; the binary point is identical for input and output.
- `FRAC_WIDTH`, 16, fractional bits. `INT_WIDTH + FRAC_WIDTH == WIDTH`.
- `GUARD`, 8, extra accumulator MSBs above `WIDTH`; must be at least 1.
- `COUNT_WIDTH`, 16, width of the term-count port.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `go`  in  1  start request; sampled only in IDLE.
- `len`  in  COUNT_WIDTH  number of terms to sum; captured on start.
- `in_valid`  in  1  input beat present.
- `in_data`  in  WIDTH  unsigned fixed-point term.
- `in_ready`  out  1  high exactly while in ACCUM.
- `out`  out  WIDTH  registered result; holds until the next start.
- `overflow`  out  1  registered; result saturated. Holds with `out`.
- `done`  out  1  one-cycle completion pulse.

## Operation
- Internal state: `acc` is `WIDTH+GUARD` bits; `cnt` and `len_q` are `COUNT_WIDTH` bits; `sticky` is 1 bit.
- Reset (asynchronous, `reset` low): state IDLE; `acc`, `cnt`, `len_q`, `sticky` = 0; `out` = 0, `overflow` = 0, `done` = 0, `in_ready` = 0.
- IDLE:
  - On `go`=1: capture `len_q` = `len`; clear `acc`, `cnt`, `sticky`; clear `out` and `overflow` to 0.
  - Next state is ACCUM if `len` != 0, otherwise FINAL.
- ACCUM: a beat is accepted when `in_valid && in_ready`.
  - `sum` = `acc + in_data`, computed `WIDTH+GUARD+1` bits wide.
  - If the carry bit of `sum` is set, `acc` = all ones and `sticky` = 1. Otherwise `acc` = `sum`.
  - `cnt` increments on each accepted beat. When the accepted beat has `cnt == len_q-1`, next state is FINAL.
  - Cycles with `in_valid`=0 are bubbles: no state change, no count.
- FINAL:
  - If `sticky` is set or `acc[WIDTH+GUARD-1:WIDTH]` != 0, then `out` = all ones and `overflow` = 1.
  - Otherwise `out` = `acc[WIDTH-1:0]` and `overflow` = 0.
  - Next state is DONE.
- DONE: `done` = 1 for exactly this cycle; next state is IDLE.
- Arithmetic: operands share one binary point, so no alignment shift is needed. Plain unsigned add, no rounding.
- `go` in any state other than IDLE is ignored; `len` is ignored outside the start cycle.
- `go` held high through DONE starts a new operation on the first IDLE cycle after DONE. That start clears `out` and `overflow`.
- Reset asserted mid-operation aborts immediately. No `done` is produced and every output returns to its reset value.

## Timing
- Start: `go` sampled at edge t; `in_ready` is high from cycle t+1.
- Last beat accepted at edge k:
  - `in_ready` drops in cycle k+1 (FINAL).
  - `out` and `overflow` are valid from edge k+2.
  - `done` is high during cycle k+2 only, aligned with `out` becoming valid.
- Total latency = 1 + (accepted beats + bubble cycles) + 2.
- `len` = 0: `done` is high during cycle t+2, with `out` = 0 and `overflow` = 0.
- Back-to-back operations: the minimum gap from one `done` cycle to the next start sample is 1 cycle (IDLE).
- `in_ready` is registered; it has no combinational path from `in_valid` or `go`.

## Test plan
- Sum, `WIDTH`=8, `INT_WIDTH`=4, `FRAC_WIDTH`=4, `GUARD`=2:
  - Stimulus: `len`=3; beats 0x10, 0x18, 0x08 (1.0 + 1.5 + 0.5).
  - Response: `out`=0x30 (3.0), `overflow`=0; `done` high exactly 2 cycles after the third beat's edge.
- Output saturation:
  - Stimulus: `len`=2; beats 0xF0, 0x20 (sum 0x110).
  - Response: `out`=0xFF, `overflow`=1.
- Guard saturation:
  - Stimulus: `len`=5; five beats of 0xFF (true sum 0x4FB exceeds 0x3FF).
  - Response: internal clamp to 0x3FF, `sticky` set; `out`=0xFF, `overflow`=1.
- Bubbles and busy `go`:
  - Stimulus: `len`=2; `in_valid` toggled 1,0,0,1 with data 0x04,x,x,0x06; `go` pulsed while in ACCUM.
  - Response: `out`=0x0A; exactly one `done`; the second `go` is ignored.
- Zero length:
  - Stimulus: `len`=0 with `go` at edge t.
  - Response: `in_ready` never high; `done` high in cycle t+2 with `out`=0x00.
- Reset mid-operation:
  - Stimulus: after 1 of 3 beats, drive `reset` low for 1 cycle, then restart with `len`=1, beat 0x07.
  - Response: outputs go to 0 with no `done` for the aborted run; the restart gives `out`=0x07, `overflow`=0.
